seq_alu: RTL and testbench

Parametrised, registered ALU for the ARM32 datapath. It extends the base 4-op combinational ALU with carry-in ops, reverse subtract, XOR, barrel shifts and an iterative multiply. Operations are accepted through a valid/ready handshake, and results and NZCV flags are returned registered. It sits between the register-file read stage and writeback, where the controller issues one operation at a time.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_mul_iter.sv | 67 ++++++
 rtl/seq_alu.sv | 171 +++++++++++++++++
 tb/tb_seq_alu.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential ALU: opcodes, flag bit positions, FSM states.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_ORR = 4'd3,
    OP_EOR = 4'd4,
    OP_ADC = 4'd5,
    OP_SBC = 4'd6,
    OP_RSB = 4'd7,
    OP_LSL = 4'd8,
    OP_LSR = 4'd9,
    OP_ASR = 4'd10,
    OP_ROR = 4'd11,
    OP_MUL = 4'd12
  } alu_op_t;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, WIDTH iterations after start.
module alu_mul_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done_c,
  output logic [WIDTH-1:0] product_c
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] acc_next_c;

  // Product of the final iteration is exposed combinationally so the top can register it on done.
  always_comb begin
    acc_next_c = acc_q + (mplier_q[0] ? mcand_q : '0);
    done_c     = busy_q && (cnt_q == CNT_W'(WIDTH - 1));
    product_c  = acc_next_c;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    if (start) begin
      acc_d    = '0;
      mcand_d  = a;
      mplier_d = b;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      acc_d    = acc_next_c;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNT_W'(1);
      busy_d   = !done_c;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

  assign busy = busy_q;

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with valid/ready issue, NZCV flags and an iterative multiply.
module seq_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter bit          MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [3:0]       ALUControl,
  input  logic             CarryIn,
  output logic             out_valid,
  output logic [WIDTH-1:0] ALUResult,
  output logic [3:0]       ALUFlags
);

  localparam int unsigned WP1 = WIDTH + 1;

  state_t           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flags_q, flags_d;

  alu_op_t            op_c;
  logic [7:0]         sh_n;
  logic [WIDTH-1:0]   add_x, add_y;
  logic               add_ci;
  logic [WIDTH:0]     sum_c, lsl_w, lsr_w;
  logic signed [WIDTH:0] asr_w;
  logic [WIDTH-1:0]   ror_w;
  int unsigned        rot;
  logic [WIDTH-1:0]   res_c;
  logic               c_c, v_c, rsv_c;
  logic [3:0]         flags_c;
  logic               accept_c, mul_start_c, mul_busy, mul_done_c;
  logic [WIDTH-1:0]   mul_prod_c;

  // Single-cycle datapath: one shared adder, shifts done on WIDTH+1 bits to expose the carry-out bit.
  always_comb begin
    op_c   = alu_op_t'(ALUControl);
    sh_n   = SrcB[7:0];
    add_x  = SrcA;
    add_y  = SrcB;
    add_ci = 1'b0;
    case (op_c)
      OP_SUB: begin add_y = ~SrcB; add_ci = 1'b1; end
      OP_ADC: add_ci = CarryIn;
      OP_SBC: begin add_y = ~SrcB; add_ci = CarryIn; end
      OP_RSB: begin add_x = SrcB; add_y = ~SrcA; add_ci = 1'b1; end
      default: ;
    endcase
    sum_c = {1'b0, add_x} + {1'b0, add_y} + WP1'(add_ci);
    lsl_w = {1'b0, SrcA} << sh_n;
    lsr_w = {SrcA, 1'b0} >> sh_n;
    asr_w = $signed({SrcA, 1'b0}) >>> sh_n;
    rot   = 32'(sh_n) % WIDTH;
    ror_w = (SrcA >> rot) | (SrcA << (WIDTH - rot));

    res_c = '0;
    c_c   = 1'b0;
    v_c   = 1'b0;
    rsv_c = 1'b0;
    case (op_c)
      OP_ADD, OP_SUB, OP_ADC, OP_SBC, OP_RSB: begin
        res_c = sum_c[WIDTH-1:0];
        c_c   = sum_c[WIDTH];
        v_c   = (add_x[WIDTH-1] == add_y[WIDTH-1]) && (sum_c[WIDTH-1] != add_x[WIDTH-1]);
      end
      OP_AND: res_c = SrcA & SrcB;
      OP_ORR: res_c = SrcA | SrcB;
      OP_EOR: res_c = SrcA ^ SrcB;
      OP_LSL: begin res_c = lsl_w[WIDTH-1:0]; c_c = lsl_w[WIDTH]; end
      OP_LSR: begin res_c = lsr_w[WIDTH:1];   c_c = lsr_w[0];     end
      OP_ASR: begin res_c = asr_w[WIDTH:1];   c_c = asr_w[0];     end
      OP_ROR: begin res_c = ror_w;            c_c = ror_w[WIDTH-1]; end
      OP_MUL: rsv_c = !MUL_EN;
      default: rsv_c = 1'b1;
    endcase
    if ((op_c inside {OP_LSL, OP_LSR, OP_ASR, OP_ROR}) && (sh_n == 8'd0)) begin
      res_c = SrcA;
      c_c   = CarryIn;
    end

    flags_c = '0;
    if (!rsv_c) begin
      flags_c[FLAG_N] = res_c[WIDTH-1];
      flags_c[FLAG_Z] = (res_c == '0);
      flags_c[FLAG_C] = c_c;
      flags_c[FLAG_V] = v_c;
    end
  end

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (mul_start_c),
    .a         (SrcA),
    .b         (SrcB),
    .busy      (mul_busy),
    .done_c    (mul_done_c),
    .product_c (mul_prod_c)
  );

  // Issue FSM and output register next-state.
  always_comb begin
    state_d     = state_q;
    out_valid_d = 1'b0;
    result_d    = result_q;
    flags_d     = flags_q;
    mul_start_c = 1'b0;
    accept_c    = in_valid && in_ready_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          if (MUL_EN && (op_c == OP_MUL)) begin
            mul_start_c = 1'b1;
            state_d     = ST_MUL;
          end else begin
            out_valid_d = 1'b1;
            result_d    = res_c;
            flags_d     = flags_c;
          end
        end
      end
      ST_MUL: begin
        if (mul_done_c) begin
          state_d         = ST_IDLE;
          out_valid_d     = 1'b1;
          result_d        = mul_prod_c;
          flags_d         = '0;
          flags_d[FLAG_N] = mul_prod_c[WIDTH-1];
          flags_d[FLAG_Z] = (mul_prod_c == '0);
        end else if (!mul_busy) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    in_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
    end else begin
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign ALUResult = result_q;
  assign ALUFlags  = flags_q;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed corner cases, MUL timing, reset abort, randomized ops vs model.
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] SrcA, SrcB;
  logic [3:0]  ALUControl;
  logic        CarryIn;
  logic        out_valid;
  logic [31:0] ALUResult;
  logic [3:0]  ALUFlags;

  int errors = 0;
  int checks = 0;

  seq_alu #(.WIDTH(32), .MUL_EN(1'b1)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .ALUControl (ALUControl),
    .CarryIn    (CarryIn),
    .out_valid  (out_valid),
    .ALUResult  (ALUResult),
    .ALUFlags   (ALUFlags)
  );

  always #5 clk = ~clk;

  function automatic bit ovf(input longint s);
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  // Reference model from arithmetic definitions on 64-bit integers.
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic cin, output logic [31:0] r, output logic [3:0] f);
    longint unsigned ua, ub, t;
    longint sa, sb, st;
    logic c, v;
    int n, rr;
    ua = {32'd0, a}; ub = {32'd0, b};
    sa = $signed(a); sb = $signed(b);
    n = int'(b[7:0]);
    c = 1'b0; v = 1'b0; r = 32'd0;
    case (op)
      4'd0: begin t = ua + ub; r = t[31:0]; c = t[32]; st = sa + sb; v = ovf(st); end
      4'd1: begin r = a - b; c = (ua >= ub); st = sa - sb; v = ovf(st); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: begin t = ua + ub + 64'(cin); r = t[31:0]; c = t[32]; st = sa + sb + 64'(cin); v = ovf(st); end
      4'd6: begin t = ua + {32'd0, ~b} + 64'(cin); r = t[31:0]; c = t[32];
                  st = sa - sb - 1 + 64'(cin); v = ovf(st); end
      4'd7: begin r = b - a; c = (ub >= ua); st = sb - sa; v = ovf(st); end
      4'd8: begin
        if (n == 0) begin r = a; c = cin; end
        else if (n > 32) begin r = 0; c = 0; end
        else begin t = ua << n; r = t[31:0]; c = t[32]; end
      end
      4'd9: begin
        if (n == 0) begin r = a; c = cin; end
        else if (n > 32) begin r = 0; c = 0; end
        else begin t = ua >> n; r = t[31:0]; c = a[n-1]; end
      end
      4'd10: begin
        if (n == 0) begin r = a; c = cin; end
        else if (n >= 32) begin r = {32{a[31]}}; c = a[31]; end
        else begin st = sa >>> n; r = st[31:0]; c = a[n-1]; end
      end
      4'd11: begin
        if (n == 0) begin r = a; c = cin; end
        else begin
          rr = n % 32;
          if (rr == 0) r = a;
          else begin t = (ua >> rr) | (ua << (32 - rr)); r = t[31:0]; end
          c = r[31];
        end
      end
      4'd12: begin t = ua * ub; r = t[31:0]; end
      default: begin f = 4'b0000; return; end
    endcase
    f = {r[31], (r == 32'd0), c, v};
  endfunction

  // Issue one op once ready, then wait (bounded) for out_valid; lat = -1 on timeout.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, output logic [31:0] r, output logic [3:0] f, output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 100) begin @(negedge clk); guard++; end
    ALUControl = op; SrcA = a; SrcB = b; CarryIn = cin; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    r = ALUResult; f = ALUFlags;
    if (!out_valid) lat = -1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; SrcA = '0; SrcB = '0; ALUControl = '0; CarryIn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (ALUResult !== 32'd0) begin errors++; $display("FAIL reset_result got=%h exp=0", ALUResult); end
    checks++; if (ALUFlags !== 4'b0000) begin errors++; $display("FAIL reset_flags got=%b exp=0000", ALUFlags); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_low got=%b exp=0", in_ready); end
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got=%b exp=1", in_ready); end
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b;
    logic        cin;
    logic [31:0] er;
    logic [3:0]  ef;
  } vec_t;

  task automatic test_directed();
    vec_t v[10];
    logic [31:0] r; logic [3:0] f; int lat;
    v[0] = '{4'd0,  32'hFFFFFFFF, 32'h1,  1'b0, 32'h0,        4'b0110};
    v[1] = '{4'd1,  32'h80000000, 32'h1,  1'b0, 32'h7FFFFFFF, 4'b0011};
    v[2] = '{4'd6,  32'h5,        32'h3,  1'b0, 32'h1,        4'b0010};
    v[3] = '{4'd9,  32'h80000001, 32'd1,  1'b0, 32'h40000000, 4'b0010};
    v[4] = '{4'd9,  32'h80000001, 32'd0,  1'b1, 32'h80000001, 4'b1010};
    v[5] = '{4'd9,  32'h80000001, 32'd40, 1'b0, 32'h0,        4'b0100};
    v[6] = '{4'd10, 32'h80000000, 32'd40, 1'b0, 32'hFFFFFFFF, 4'b1010};
    v[7] = '{4'd8,  32'h00000001, 32'd32, 1'b0, 32'h0,        4'b0110};
    v[8] = '{4'd11, 32'h00000001, 32'd33, 1'b0, 32'h80000000, 4'b1010};
    v[9] = '{4'd13, 32'h00000001, 32'h1,  1'b1, 32'h0,        4'b0000};
    for (int i = 0; i < 10; i++) begin
      run_op(v[i].op, v[i].a, v[i].b, v[i].cin, r, f, lat);
      checks++; if (lat != 1) begin errors++; $display("FAIL dir%0d_latency got=%0d exp=1", i, lat); end
      checks++; if (r !== v[i].er) begin errors++; $display("FAIL dir%0d_result got=%h exp=%h", i, r, v[i].er); end
      checks++; if (f !== v[i].ef) begin errors++; $display("FAIL dir%0d_flags got=%b exp=%b", i, f, v[i].ef); end
      if (i == 0) begin
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL out_valid_pulse got=%b exp=0", out_valid); end
      end
    end
  endtask

  // MUL with a different op held on the bus; that op issues in the MUL out_valid cycle.
  task automatic test_mul_back_to_back();
    int lat, low_cnt;
    @(negedge clk);
    ALUControl = 4'd12; SrcA = 32'h00010000; SrcB = 32'h00010001; CarryIn = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    ALUControl = 4'd0; SrcA = 32'd2; SrcB = 32'd3;
    lat = 1; low_cnt = 0;
    while (!out_valid && lat < 100) begin
      if (in_ready === 1'b0) low_cnt++;
      @(posedge clk); #1; lat++;
    end
    checks++; if (lat != 33) begin errors++; $display("FAIL mul_latency got=%0d exp=33", lat); end
    checks++; if (low_cnt != 32) begin errors++; $display("FAIL mul_ready_low got=%0d exp=32", low_cnt); end
    checks++; if (ALUResult !== 32'h00010000) begin errors++; $display("FAIL mul_result got=%h exp=00010000", ALUResult); end
    checks++; if (ALUFlags !== 4'b0000) begin errors++; $display("FAIL mul_flags got=%b exp=0000", ALUFlags); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mul_done_ready got=%b exp=1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_out_valid got=%b exp=1", out_valid); end
    checks++; if (ALUResult !== 32'h5) begin errors++; $display("FAIL b2b_result got=%h exp=00000005", ALUResult); end
    checks++; if (ALUFlags !== 4'b0000) begin errors++; $display("FAIL b2b_flags got=%b exp=0000", ALUFlags); end
  endtask

  task automatic test_reset_mid_mul();
    int seen;
    logic [31:0] r, er; logic [3:0] f, ef; int lat;
    @(negedge clk);
    ALUControl = 4'd12; SrcA = 32'h1234; SrcB = 32'h5678; CarryIn = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1; reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_out_valid got=%b exp=0", out_valid); end
    checks++; if (ALUResult !== 32'd0) begin errors++; $display("FAIL abort_result got=%h exp=0", ALUResult); end
    checks++; if (ALUFlags !== 4'b0000) begin errors++; $display("FAIL abort_flags got=%b exp=0000", ALUFlags); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL abort_ready_low got=%b exp=0", in_ready); end
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_ready_release got=%b exp=1", in_ready); end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid === 1'b1) seen++;
      @(posedge clk); #1;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL abort_no_out_valid got=%0d exp=0", seen); end
    run_op(4'd0, 32'h7FFFFFFF, 32'h1, 1'b0, r, f, lat);
    model(4'd0, 32'h7FFFFFFF, 32'h1, 1'b0, er, ef);
    checks++; if (lat != 1 || r !== er || f !== ef) begin
      errors++; $display("FAIL post_reset_add got=%h/%b lat=%0d exp=%h/%b lat=1", r, f, lat, er, ef);
    end
  endtask

  task automatic test_random();
    logic [3:0] op; logic [31:0] a, b, r, er; logic cin; logic [3:0] f, ef; int lat, elat;
    for (int i = 0; i < 150; i++) begin
      op = 4'($urandom_range(0, 15));
      a = $urandom; b = $urandom; cin = 1'($urandom);
      case ($urandom_range(0, 3))
        0: a = 32'h80000000;
        1: b = ~a;
        default: ;
      endcase
      if (op >= 4'd8 && op <= 4'd11) b[7:0] = 8'($urandom_range(0, 40));
      if (op == 4'd12 && $urandom_range(0, 1) == 0) b = $urandom_range(0, 255);
      model(op, a, b, cin, er, ef);
      elat = (op == 4'd12) ? 33 : 1;
      run_op(op, a, b, cin, r, f, lat);
      checks++;
      if (lat != elat || r !== er || f !== ef) begin
        errors++;
        $display("FAIL rand%0d op=%0d a=%h b=%h cin=%b got=%h/%b lat=%0d exp=%h/%b lat=%0d",
                 i, op, a, b, cin, r, f, lat, er, ef, elat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_mul_back_to_back();
    test_reset_mid_mul();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
